// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-side memory responder.
//   - Memory-mapped register addresses (byte addresses, word aligned).
//   - Bit positions of the fields inside the STATUS register.
package dmem_pkg;

  localparam logic [31:0] TX_DATA_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] STATUS_ADDR  = 32'hFFFF_FF04;
  localparam logic [31:0] CYCLES_ADDR  = 32'hFFFF_FF08;

  // STATUS layout: [7:4] occupancy, [2] misalign, [1] overflow, [0] full
  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_OVF_BIT      = 1;
  localparam int STATUS_MISALIGN_BIT = 2;
  localparam int STATUS_OCC_LSB      = 4;
  localparam int STATUS_OCC_W        = 4;

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: circular-buffer FIFO feeding the console TX drain port.
// Ports:
//   CLK        rising-edge clock
//   rst        synchronous active-low reset (empties the FIFO)
//   push       write request; accepted when not full, or when a pop
//              happens in the same cycle (occupancy then stays put)
//   push_data  word written on an accepted push
//   pop        read request; ignored when empty
//   head       word at the head of the queue (registered storage)
//   empty      no entries held
//   full       DEPTH entries held
//   count      occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory for the single-cycle core.
// Word RAM at 0x0 .. MEM_WORDS*4-1 plus memory-mapped registers:
//   0xFFFF_FF00 TX_DATA  store pushes console word; reads 0
//   0xFFFF_FF04 STATUS   {occupancy[7:4], misalign[2], overflow[1], full[0]};
//                        any store clears the sticky bits
//   0xFFFF_FF08 CYCLES   free-running cycle counter; a store zeroes it
// Ports:
//   CLK, rst        clock and synchronous active-low reset (RAM retained)
//   Addr            byte address from the datapath
//   WriteData       store data; MemWrite store strobe
//   MemRead         load qualifier; ReadData is 0 when low or in reset
//   ReadData        combinational load data
//   TxData/TxValid  console drain port, head word and non-empty flag
//   TxReady         consumer ready
//   Overflow        sticky: store to TX_DATA dropped because FIFO full
// Drain handshake: a word transfers on a rising CLK where TxValid and
// TxReady are both high; while TxValid is high and TxReady low, TxData
// holds its value. TxValid never depends on TxReady.
// Configuration macro DMEM_ALIGN_CHECK_EN: when defined, accesses with
// Addr[1:0]!=0 are suppressed, read 0 and set sticky STATUS[2]; when
// undefined, Addr[1:0] is ignored and STATUS[2] reads 0.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic [DATA_WIDTH-1:0] TxData,
  output logic                  TxValid,
  input  logic                  TxReady,
  output logic                  Overflow
);

  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = ADDR_WIDTH'(MEM_WORDS * 4);
  localparam logic [ADDR_WIDTH-1:0] TX_A      = ADDR_WIDTH'(TX_DATA_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STATUS_A  = ADDR_WIDTH'(STATUS_ADDR);
  localparam logic [ADDR_WIDTH-1:0] CYCLES_A  = ADDR_WIDTH'(CYCLES_ADDR);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] cycle_q;
  logic [DATA_WIDTH-1:0] status_word;
  logic                  ovf_q;
  logic                  misalign_bit;
  logic                  access_ok;
  logic                  in_ram, is_tx, is_status, is_cycles;
  logic                  wr_en, tx_store;
  logic                  fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]      fifo_count;

  // Register decode compares word addresses only; the byte offset is
  // either ignored or handled by the alignment check below.
  assign in_ram    = (Addr < RAM_LIMIT);
  assign is_tx     = (Addr[ADDR_WIDTH-1:2] == TX_A[ADDR_WIDTH-1:2]);
  assign is_status = (Addr[ADDR_WIDTH-1:2] == STATUS_A[ADDR_WIDTH-1:2]);
  assign is_cycles = (Addr[ADDR_WIDTH-1:2] == CYCLES_A[ADDR_WIDTH-1:2]);

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned = (Addr[1:0] != 2'b00) && (MemRead || MemWrite);
  assign access_ok  = !misaligned;

  // A misaligned access can never also be the aligned STATUS store that
  // clears the bit, so set and clear are mutually exclusive.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else if (misaligned) begin
      misalign_q <= 1'b1;
    end else if (wr_en && is_status) begin
      misalign_q <= 1'b0;
    end
  end

  assign misalign_bit = misalign_q;
`else
  logic unused_low_addr;

  assign unused_low_addr = ^Addr[1:0];
  assign access_ok       = 1'b1;
  assign misalign_bit    = 1'b0;
`endif

  assign wr_en    = MemWrite && access_ok;
  assign tx_store = wr_en && is_tx;
  assign fifo_pop = !fifo_empty && TxReady;

  tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_tx_fifo (
    .CLK       (CLK),
    .rst       (rst),
    .push      (tx_store),
    .push_data (WriteData),
    .pop       (fifo_pop),
    .head      (TxData),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign TxValid  = !fifo_empty;
  assign Overflow = ovf_q;

  // RAM has no reset; stores are ignored while reset is asserted.
  always_ff @(posedge CLK) begin
    if (rst && wr_en && in_ram) begin
      mem[Addr[RAM_AW+1:2]] <= WriteData;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      cycle_q <= '0;
    end else if (wr_en && is_cycles) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
    end
  end

  // Overflow only when the head is not leaving in the same cycle.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (tx_store && fifo_full && !fifo_pop) begin
      ovf_q <= 1'b1;
    end else if (wr_en && is_status) begin
      ovf_q <= 1'b0;
    end
  end

  always_comb begin
    status_word                                      = '0;
    status_word[STATUS_FULL_BIT]                     = fifo_full;
    status_word[STATUS_OVF_BIT]                      = ovf_q;
    status_word[STATUS_MISALIGN_BIT]                 = misalign_bit;
    status_word[STATUS_OCC_LSB +: STATUS_OCC_W]      = STATUS_OCC_W'(fifo_count);
  end

  // Combinational load path; a same-cycle store is seen only after the edge.
  always_comb begin
    ReadData = '0;
    if (rst && MemRead && access_ok) begin
      if (in_ram) begin
        ReadData = mem[Addr[RAM_AW+1:2]];
      end else if (is_status) begin
        ReadData = status_word;
      end else if (is_cycles) begin
        ReadData = cycle_q;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder.
module tb_data_mem_responder;

  localparam logic [31:0] A_TX     = 32'hFFFF_FF00;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF04;
  localparam logic [31:0] A_CYCLES = 32'hFFFF_FF08;
  localparam logic [31:0] A_UNMAP  = 32'hFFFF_FF40;

  logic        CLK;
  logic        rst;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic [31:0] TxData;
  logic        TxValid;
  logic        TxReady;
  logic        Overflow;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  data_mem_responder dut (
    .CLK       (CLK),
    .rst       (rst),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxReady   (TxReady),
    .Overflow  (Overflow)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic set_bus(input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic re);
    Addr      = a;
    WriteData = wd;
    MemWrite  = we;
    MemRead   = re;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd);
    set_bus(a, wd, 1'b1, 1'b0);
    tick();
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_check(input string tag, input logic [31:0] a,
                            input logic [31:0] exp);
    set_bus(a, 32'h0, 1'b0, 1'b1);
    check(tag, ReadData, exp);
  endtask

  // Drain exp_q through the TX port, checking order and final emptiness.
  task automatic drain(input string tag);
    TxReady = 1'b1;
    for (int guard = 0; guard < 20 && exp_q.size() > 0; guard++) begin
      check({tag, "_valid"}, {31'b0, TxValid}, 32'd1);
      check({tag, "_data"}, TxData, exp_q.pop_front());
      tick();
    end
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    check({tag, "_valid_low"}, {31'b0, TxValid}, 32'd0);
    TxReady = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    TxReady = 1'b0;
    Addr = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
    @(negedge CLK);
    tick();
    tick();

    // Reset state: loads forced to zero, drain port idle.
    load_check("reset_read_status", A_STATUS, 32'h0);
    check("reset_txvalid", {31'b0, TxValid}, 32'd0);
    check("reset_overflow", {31'b0, Overflow}, 32'd0);
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    // Cycle counter: 5 edges after reset release.
    repeat (5) tick();
    load_check("cycles_after_5", A_CYCLES, 32'd5);
    store(A_CYCLES, 32'h1234);
    load_check("cycles_after_store", A_CYCLES, 32'd0);
    tick();
    load_check("cycles_next", A_CYCLES, 32'd1);
    load_check("status_idle", A_STATUS, 32'h0);

    // RAM store/load and MemRead gating.
    store(32'h10, 32'hDEAD_BEEF);
    load_check("ram_load_0x10", 32'h10, 32'hDEAD_BEEF);
    set_bus(32'h10, 32'h0, 1'b0, 1'b0);
    check("memread_low", ReadData, 32'h0);
    store(32'h14, 32'h0BAD_F00D);
    load_check("ram_load_0x14", 32'h14, 32'h0BAD_F00D);
    load_check("ram_0x10_kept", 32'h10, 32'hDEAD_BEEF);

    // Read during write returns old data; new data after the edge.
    set_bus(32'h10, 32'h1234_5678, 1'b1, 1'b1);
    check("rdw_old_data", ReadData, 32'hDEAD_BEEF);
    tick();
    load_check("rdw_new_data", 32'h10, 32'h1234_5678);
    load_check("tx_data_reads_zero", A_TX, 32'h0);

    // Fill FIFO with 1..9 while blocked: 9 is dropped, overflow set.
    TxReady = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      set_bus(A_TX, i, 1'b1, 1'b0);
      if (i <= 8) exp_q.push_back(i);
      tick();
    end
    load_check("status_full_ovf", A_STATUS, 32'h0000_0083);
    check("overflow_set", {31'b0, Overflow}, 32'd1);
    check("head_stable", TxData, 32'd1);
    tick();
    check("head_stable_2", TxData, 32'd1);
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    drain("drain1");
    check("overflow_sticky", {31'b0, Overflow}, 32'd1);
    load_check("status_after_drain", A_STATUS, 32'h0000_0002);

    // Any STATUS store clears the sticky overflow.
    store(A_STATUS, 32'h0);
    check("overflow_cleared", {31'b0, Overflow}, 32'd0);
    load_check("status_cleared", A_STATUS, 32'h0);

    // Full FIFO, push and pop in the same cycle.
    for (int i = 0; i < 8; i++) begin
      set_bus(A_TX, 32'h11 + i, 1'b1, 1'b0);
      exp_q.push_back(32'h11 + i);
      tick();
    end
    load_check("status_full", A_STATUS, 32'h0000_0081);
    TxReady = 1'b1;
    set_bus(A_TX, 32'hAA, 1'b1, 1'b0);
    check("pushpop_head", TxData, exp_q.pop_front());
    exp_q.push_back(32'hAA);
    tick();
    TxReady = 1'b0;
    load_check("status_pushpop", A_STATUS, 32'h0000_0081);
    check("pushpop_no_ovf", {31'b0, Overflow}, 32'd0);
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    drain("drain2");

    // Push into empty FIFO: not visible until next cycle.
    TxReady = 1'b1;
    set_bus(A_TX, 32'h55, 1'b1, 1'b0);
    check("no_bypass", {31'b0, TxValid}, 32'd0);
    tick();
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    check("single_valid", {31'b0, TxValid}, 32'd1);
    check("single_data", TxData, 32'h55);
    tick();
    check("single_popped", {31'b0, TxValid}, 32'd0);
    TxReady = 1'b0;

    // Unmapped address: reads 0, store changes nothing.
    load_check("unmapped_read", A_UNMAP, 32'h0);
    store(A_UNMAP, 32'hCAFE_0001);
    load_check("unmapped_read2", A_UNMAP, 32'h0);
    load_check("unmapped_ram_kept", 32'h10, 32'h1234_5678);
    load_check("unmapped_status", A_STATUS, 32'h0);
    check("unmapped_no_tx", {31'b0, TxValid}, 32'd0);

    // Misaligned store at 0x12.
    store(32'h12, 32'h77);
`ifdef DMEM_ALIGN_CHECK_EN
    load_check("align_ram_kept", 32'h10, 32'h1234_5678);
    load_check("align_status", A_STATUS, 32'h0000_0004);
    load_check("align_read_zero", 32'h11, 32'h0);
`else
    load_check("align_ram_written", 32'h10, 32'h77);
    load_check("align_status", A_STATUS, 32'h0);
    load_check("align_read_word", 32'h11, 32'h77);
`endif
    store(A_STATUS, 32'h0);
    load_check("align_status_cleared", A_STATUS, 32'h0);

    // Reset mid-operation: FIFO discarded, RAM retained.
    set_bus(A_TX, 32'h66, 1'b1, 1'b0);
    tick();
    set_bus(A_TX, 32'h67, 1'b1, 1'b0);
    tick();
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    check("pre_reset_valid", {31'b0, TxValid}, 32'd1);
    rst = 1'b0;
    tick();
    check("midreset_valid", {31'b0, TxValid}, 32'd0);
    load_check("midreset_read_zero", 32'h14, 32'h0);
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    load_check("ram_retained", 32'h14, 32'h0BAD_F00D);
    load_check("status_after_reset", A_STATUS, 32'h0);
    tick();
    load_check("cycles_after_reset", A_CYCLES, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
